// File: rtl/phy_detect_ctrl.sv
// rtl/phy_detect_ctrl.sv - PHY power-up handshake and receiver-detect sequencer
module phy_detect_ctrl #(
    parameter int PWRUP_CYCLES = 16,
    parameter int DET_WAIT     = 8
) (
    input  logic clock,
    input  logic Reset,
    input  logic TXDETECTRX,
    input  logic TXELECIDLE,
    input  logic RXDET_O,
    output logic TXIDLE,
    output logic RXDET,
    output logic PHYSTATUS,
    output logic RX_PRESENT,
    output logic BUSY
);

    typedef enum logic [2:0] {
        S_PWRUP      = 3'd0,
        S_PWRUP_DONE = 3'd1,
        S_IDLE       = 3'd2,
        S_DETECT     = 3'd3,
        S_REPORT     = 3'd4,
        S_WAIT_REL   = 3'd5
    } state_t;

    // Terminal counts; both are at most 254 so the 8-bit counter never wraps.
    localparam logic [7:0] C_PWRUP_LAST = 8'(PWRUP_CYCLES - 1);
    localparam logic [7:0] C_DET_LAST   = 8'(DET_WAIT - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_det_cap;

    state_t     w_next_state;
    logic [7:0] w_next_cnt;
    logic       w_next_det_cap;

    logic       r_txidle;
    logic       r_rxdet;
    logic       r_phystatus;
    logic       r_rx_present;
    logic       r_busy;

    // State register: reset restarts the power-up sequence from any state.
    always_ff @(posedge clock) begin
        if (!Reset) begin
            r_state   <= S_PWRUP;
            r_cnt     <= 8'd0;
            r_det_cap <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_det_cap <= w_next_det_cap;
        end
    end

    // Next-state, counter and detect-capture logic.
    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_next_det_cap = r_det_cap;
        case (r_state)
            S_PWRUP: begin
                if (r_cnt == C_PWRUP_LAST) begin
                    w_next_state = S_PWRUP_DONE;
                    w_next_cnt   = 8'd0;
                end else begin
                    w_next_cnt = r_cnt + 8'd1;
                end
            end
            S_PWRUP_DONE: begin
                w_next_state = S_IDLE;
            end
            S_IDLE: begin
                // A request without electrical idle is a loopback request and is ignored.
                if (TXDETECTRX && TXELECIDLE) begin
                    w_next_state = S_DETECT;
                end
            end
            S_DETECT: begin
                if (r_cnt == C_DET_LAST) begin
                    w_next_det_cap = RXDET_O;
                    w_next_cnt     = 8'd0;
                    w_next_state   = S_REPORT;
                end else begin
                    w_next_cnt = r_cnt + 8'd1;
                end
            end
            S_REPORT: begin
                w_next_state = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                // Wait for the MAC to drop the level request so it cannot retrigger.
                if (!TXDETECTRX) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_PWRUP;
                w_next_cnt   = 8'd0;
            end
        endcase
    end

    // Registered Moore outputs decoded from the current state.
    always_ff @(posedge clock) begin
        if (!Reset) begin
            r_txidle     <= 1'b1;
            r_rxdet      <= 1'b0;
            r_phystatus  <= 1'b0;
            r_rx_present <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            r_txidle     <= (r_state == S_IDLE) ? TXELECIDLE : 1'b1;
            r_rxdet      <= (r_state == S_DETECT);
            r_phystatus  <= (r_state == S_PWRUP_DONE) || (r_state == S_REPORT);
            r_rx_present <= (r_state == S_REPORT) && r_det_cap;
            r_busy       <= (r_state != S_IDLE);
        end
    end

    assign TXIDLE     = r_txidle;
    assign RXDET      = r_rxdet;
    assign PHYSTATUS  = r_phystatus;
    assign RX_PRESENT = r_rx_present;
    assign BUSY       = r_busy;

endmodule

// File: tb/tb_phy_detect_ctrl.sv
// tb/tb_phy_detect_ctrl.sv - scoreboard bench for phy_detect_ctrl
module tb_phy_detect_ctrl;

    localparam int A_PWRUP = 16;
    localparam int A_DET   = 8;
    localparam int B_PWRUP = 3;
    localparam int B_DET   = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic a_reset, a_det, a_eidle, a_rxo;
    logic a_txidle, a_rxdet, a_phys, a_rxp, a_busy;
    logic b_reset, b_det, b_eidle, b_rxo;
    logic b_txidle, b_rxdet, b_phys, b_rxp, b_busy;

    phy_detect_ctrl #(.PWRUP_CYCLES(A_PWRUP), .DET_WAIT(A_DET)) u_dut_a (
        .clock(clock), .Reset(a_reset), .TXDETECTRX(a_det), .TXELECIDLE(a_eidle),
        .RXDET_O(a_rxo), .TXIDLE(a_txidle), .RXDET(a_rxdet), .PHYSTATUS(a_phys),
        .RX_PRESENT(a_rxp), .BUSY(a_busy)
    );

    phy_detect_ctrl #(.PWRUP_CYCLES(B_PWRUP), .DET_WAIT(B_DET)) u_dut_b (
        .clock(clock), .Reset(b_reset), .TXDETECTRX(b_det), .TXELECIDLE(b_eidle),
        .RXDET_O(b_rxo), .TXIDLE(b_txidle), .RXDET(b_rxdet), .PHYSTATUS(b_phys),
        .RX_PRESENT(b_rxp), .BUSY(b_busy)
    );

    typedef struct {
        int cyc;
        bit rx;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_exp(input int id, input int c, input bit rx);
        exp_t e;
        e.cyc = c;
        e.rx  = rx;
        if (id == 0) q_a.push_back(e);
        else         q_b.push_back(e);
    endtask

    // Monitor: every PHYSTATUS pulse must match the head of the expected queue.
    task automatic mon(input int id, input logic phys, input logic rxp);
        exp_t e;
        logic [2:0] rxstatus;
        int qsize;
        rxstatus = (phys && rxp) ? 3'b011 : 3'b000;
        qsize = (id == 0) ? q_a.size() : q_b.size();
        if (phys) begin
            if (qsize == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_phystatus dut=%0d cyc=%0d actual=1 required=0", id, cyc);
            end else begin
                if (id == 0) e = q_a.pop_front();
                else         e = q_b.pop_front();
                chk($sformatf("phystatus_cycle_dut%0d", id), cyc, e.cyc);
                chk($sformatf("rx_present_dut%0d", id), int'(rxp), int'(e.rx));
                chk($sformatf("rxstatus_dut%0d", id), int'(rxstatus), e.rx ? 3 : 0);
            end
        end else begin
            chk($sformatf("rx_present_idle_dut%0d", id), int'(rxp), 0);
        end
    endtask

    always @(negedge clock) mon(0, a_phys, a_rxp);
    always @(negedge clock) mon(1, b_phys, b_rxp);

    // Raise a detect request on DUT A with RXDET_O held and check the RXDET window.
    task automatic run_detect_a(input bit rxo);
        int k;
        k = cyc + 1;
        a_rxo = rxo;
        a_det = 1'b1;
        push_exp(0, k + A_DET + 1, rxo);
        for (int i = 0; i < A_DET + 3; i++) begin
            tick(1);
            chk("rxdet_window", int'(a_rxdet), int'((cyc >= k + 1) && (cyc <= k + A_DET)));
        end
    endtask

    // Detect on DUT B with RXDET_O changing every cycle; pat[2] lands on the sampling edge.
    task automatic run_toggle_b(input logic [3:0] pat);
        int k;
        k = cyc + 1;
        b_det = 1'b1;
        push_exp(1, k + B_DET + 1, pat[2]);
        for (int i = 0; i < 4; i++) begin
            b_rxo = pat[i];
            tick(1);
        end
        tick(2);
        b_det = 1'b0;
        tick(2);
        chk("b_busy_after_release", int'(b_busy), 0);
    endtask

    int c;
    int k;

    initial begin
        a_reset = 1'b0; a_det = 1'b0; a_eidle = 1'b1; a_rxo = 1'b0;
        b_reset = 1'b0; b_det = 1'b0; b_eidle = 1'b1; b_rxo = 1'b0;
        tick(3);

        chk("reset_txidle", int'(a_txidle), 1);
        chk("reset_rxdet", int'(a_rxdet), 0);
        chk("reset_phystatus", int'(a_phys), 0);
        chk("reset_rx_present", int'(a_rxp), 0);
        chk("reset_busy", int'(a_busy), 1);

        // Power-up: pulse PWRUP_CYCLES after the release edge.
        c = cyc;
        a_reset = 1'b1;
        push_exp(0, c + 1 + A_PWRUP, 1'b0);
        tick(A_PWRUP);
        chk("pwrup_busy_high", int'(a_busy), 1);
        tick(2);
        chk("idle_busy_low", int'(a_busy), 0);
        chk("idle_txidle_follow1", int'(a_txidle), 1);
        a_eidle = 1'b0;
        tick(2);
        chk("idle_txidle_follow0", int'(a_txidle), 0);
        a_eidle = 1'b1;
        tick(2);
        chk("idle_txidle_follow1b", int'(a_txidle), 1);

        // Receiver present, request held long: no retrigger.
        run_detect_a(1'b1);
        tick(20);
        chk("wait_rel_busy", int'(a_busy), 1);
        chk("wait_rel_txidle", int'(a_txidle), 1);
        a_det = 1'b0;
        tick(2);
        chk("release_busy_low", int'(a_busy), 0);

        // Receiver absent, then drop and re-raise one cycle later.
        run_detect_a(1'b0);
        tick(3);
        a_det = 1'b0;
        tick(1);
        run_detect_a(1'b1);
        a_det = 1'b0;
        tick(2);
        chk("second_release_busy", int'(a_busy), 0);

        // Loopback request is ignored.
        a_eidle = 1'b0;
        tick(2);
        a_det = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            chk("loopback_rxdet", int'(a_rxdet), 0);
            chk("loopback_busy", int'(a_busy), 0);
            chk("loopback_txidle", int'(a_txidle), 0);
        end
        a_det = 1'b0;
        tick(1);
        a_eidle = 1'b1;
        tick(2);

        // Reset in the middle of a detect.
        k = cyc + 1;
        a_rxo = 1'b1;
        a_det = 1'b1;
        tick(2);
        chk("abort_rxdet_before", int'(a_rxdet), 1);
        a_reset = 1'b0;
        tick(1);
        chk("abort_rxdet_after", int'(a_rxdet), 0);
        chk("abort_busy", int'(a_busy), 1);
        tick(1);
        a_det = 1'b0;
        c = cyc;
        a_reset = 1'b1;
        push_exp(0, c + 1 + A_PWRUP, 1'b0);
        tick(A_PWRUP + 2);
        chk("abort_repwrup_busy", int'(a_busy), 0);
        tick(10);

        // DUT B: short power-up, DET_WAIT=2 with toggling RXDET_O.
        c = cyc;
        b_reset = 1'b1;
        push_exp(1, c + 1 + B_PWRUP, 1'b0);
        tick(B_PWRUP + 2);
        chk("b_idle_busy", int'(b_busy), 0);
        run_toggle_b(4'b0101);
        run_toggle_b(4'b1010);
        run_toggle_b(4'b1011);
        run_toggle_b(4'b0100);
        tick(5);

        chk("q_a_drained", q_a.size(), 0);
        chk("q_b_drained", q_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
